// File: rtl/bus_sequencer_if.sv
// Core load/store port and 8-bit external bus of the bus sequencer, bundled as one interface.
// The slave modport is the sequencer; the master modport is the core plus external bus device.
interface bus_sequencer_if #(
  parameter int BUS_ADDRESS_WIDTH = 8
);
  logic                         request;
  logic                         write_enable;
  logic [2:0]                   size;
  logic [BUS_ADDRESS_WIDTH-1:0] address;
  logic [31:0]                  write_data;
  logic [31:0]                  read_data;
  logic                         done;
  logic                         busy;
  logic [BUS_ADDRESS_WIDTH-1:0] bus_address;
  logic                         bus_write_enable;
  logic [7:0]                   bus_write_data;
  logic [7:0]                   bus_read_data;
  logic [7:0]                   bus_output_enable;

  modport slave (
    input  request, write_enable, size, address, write_data, bus_read_data,
    output read_data, done, busy, bus_address, bus_write_enable, bus_write_data,
           bus_output_enable
  );

  modport master (
    output request, write_enable, size, address, write_data, bus_read_data,
    input  read_data, done, busy, bus_address, bus_write_enable, bus_write_data,
           bus_output_enable
  );
endinterface

// File: rtl/bus_sequencer.sv
// Splits 32-bit core loads/stores into little-endian byte transfers on an 8-bit bus,
// with WAIT_STATES extra cycles per byte and sign/zero extension of load results.
module bus_sequencer #(
  parameter int BUS_ADDRESS_WIDTH = 8,
  parameter int WAIT_STATES       = 0
) (
  input logic             clock,
  input logic             reset_n,
  bus_sequencer_if.slave  bif
);
  localparam int AW = BUS_ADDRESS_WIDTH;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state_q;
  logic [1:0]    j_q, last_q;
  logic [3:0]    wait_q;
  logic          we_q;
  logic [2:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q, rbuf_q;
  logic [31:0]   read_data_q;
  logic          done_q;
  logic [AW-1:0] bus_addr_q;
  logic          bus_we_q;
  logic [7:0]    bus_wdata_q;

  logic          start_d, phase_end_d;
  logic [1:0]    j_next_d;
  logic [31:0]   rd_word_d;

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] sz);
    case (sz[1:0])
      2'd0:    extend = {{24{~sz[2] & w[7]}}, w[7:0]};
      2'd1:    extend = {{16{~sz[2] & w[15]}}, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  function automatic logic [1:0] last_index(input logic [1:0] sz);
    case (sz)
      2'd0:    last_index = 2'd0;
      2'd1:    last_index = 2'd1;
      default: last_index = 2'd3;
    endcase
  endfunction

  // The byte arriving on the final edge of a phase is merged in combinationally so the
  // extended result can be registered on the same edge that enters DONE.
  always_comb begin
    start_d     = (state_q == IDLE) && bif.request;
    phase_end_d = (state_q == ACCESS) && (wait_q == 4'd0);
    j_next_d    = j_q + 2'd1;
    rd_word_d   = put_byte(rbuf_q, j_q, bif.bus_read_data);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      j_q         <= 2'd0;
      last_q      <= 2'd0;
      wait_q      <= 4'd0;
      we_q        <= 1'b0;
      size_q      <= 3'd0;
      read_data_q <= 32'd0;
      done_q      <= 1'b0;
      bus_addr_q  <= '0;
      bus_we_q    <= 1'b0;
      bus_wdata_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bif.request) begin
            state_q     <= ACCESS;
            we_q        <= bif.write_enable;
            size_q      <= bif.size;
            last_q      <= last_index(bif.size[1:0]);
            j_q         <= 2'd0;
            wait_q      <= WS;
            bus_addr_q  <= bif.address;
            bus_we_q    <= bif.write_enable;
            bus_wdata_q <= bif.write_data[7:0];
          end
        end
        ACCESS: begin
          if (wait_q != 4'd0) begin
            wait_q <= wait_q - 4'd1;
          end else if (j_q == last_q) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            bus_we_q <= 1'b0;
            if (!we_q) read_data_q <= extend(rd_word_d, size_q);
          end else begin
            j_q         <= j_next_d;
            wait_q      <= WS;
            bus_addr_q  <= addr_q + AW'(j_next_d);
            bus_wdata_q <= wdata_q[{j_next_d, 3'b000} +: 8];
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Latched request data and the load assembly buffer need no reset.
  always_ff @(posedge clock) begin
    if (start_d) begin
      addr_q  <= bif.address;
      wdata_q <= bif.write_data;
    end
    if (phase_end_d && !we_q) rbuf_q <= rd_word_d;
  end

  assign bif.read_data         = read_data_q;
  assign bif.done              = done_q;
  assign bif.busy              = (state_q != IDLE);
  assign bif.bus_address       = bus_addr_q;
  assign bif.bus_write_enable  = bus_we_q;
  assign bif.bus_write_data    = bus_wdata_q;
  assign bif.bus_output_enable = {8{bus_we_q}};
endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench: two sequencers (0 and 2 wait states) against a byte-memory reference model.
module tb_bus_sequencer;
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic [1:0]       req, we;
  logic [1:0][2:0]  sz;
  logic [1:0][7:0]  ad;
  logic [1:0][31:0] wd;
  logic [7:0]       mem  [2][256];
  logic [7:0]       refm [2][256];
  logic [31:0]      last_rd [2];

  logic [1:0]       done_o, busy_o, bwe_o;
  logic [1:0][31:0] rd_o;
  logic [1:0][7:0]  ba_o, bwd_o, boe_o;

  int n_cmp, n_bad;

  bus_sequencer_if #(.BUS_ADDRESS_WIDTH(8)) if0 (), if2 ();

  bus_sequencer #(.BUS_ADDRESS_WIDTH(8), .WAIT_STATES(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .bif(if0));
  bus_sequencer #(.BUS_ADDRESS_WIDTH(8), .WAIT_STATES(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .bif(if2));

  assign if0.request = req[0];  assign if0.write_enable = we[0];
  assign if0.size    = sz[0];   assign if0.address      = ad[0];
  assign if0.write_data = wd[0];
  assign if0.bus_read_data = mem[0][if0.bus_address];
  assign if2.request = req[1];  assign if2.write_enable = we[1];
  assign if2.size    = sz[1];   assign if2.address      = ad[1];
  assign if2.write_data = wd[1];
  assign if2.bus_read_data = mem[1][if2.bus_address];

  assign done_o[0] = if0.done;  assign busy_o[0] = if0.busy;  assign bwe_o[0] = if0.bus_write_enable;
  assign rd_o[0] = if0.read_data; assign ba_o[0] = if0.bus_address;
  assign bwd_o[0] = if0.bus_write_data; assign boe_o[0] = if0.bus_output_enable;
  assign done_o[1] = if2.done;  assign busy_o[1] = if2.busy;  assign bwe_o[1] = if2.bus_write_enable;
  assign rd_o[1] = if2.read_data; assign ba_o[1] = if2.bus_address;
  assign bwd_o[1] = if2.bus_write_data; assign boe_o[1] = if2.bus_output_enable;

  task automatic chk(input string tag, input int s, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s dut%0d observed=%08h expected=%08h", tag, s, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  function automatic int nbytes(input logic [2:0] size);
    return (size[1:0] == 2'd0) ? 1 : (size[1:0] == 2'd1) ? 2 : 4;
  endfunction

  // Little-endian value of n bytes from the reference memory, then two's-complement
  // reinterpretation for signed narrow loads.
  function automatic logic [31:0] model_load(input int s, input logic [2:0] size, input logic [7:0] addr);
    longint v;
    int n;
    n = nbytes(size);
    v = 0;
    for (int i = 0; i < n; i++)
      v += longint'(refm[s][(int'(addr) + i) % 256]) << (8 * i);
    if (!size[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v -= longint'(1) << (8 * n);
    return 32'(v);
  endfunction

  task automatic check_zero(input int s);
    chk("rst_read_data", s, rd_o[s], 32'd0);
    chk("rst_done", s, 32'(done_o[s]), 32'd0);
    chk("rst_busy", s, 32'(busy_o[s]), 32'd0);
    chk("rst_bus_we", s, 32'(bwe_o[s]), 32'd0);
    chk("rst_bus_addr", s, 32'(ba_o[s]), 32'd0);
    chk("rst_bus_wdata", s, 32'(bwd_o[s]), 32'd0);
    chk("rst_bus_oe", s, 32'(boe_o[s]), 32'd0);
  endtask

  task automatic check_idle(input int s, input logic [7:0] held_addr);
    chk("idle_done", s, 32'(done_o[s]), 32'd0);
    chk("idle_busy", s, 32'(busy_o[s]), 32'd0);
    chk("idle_bus_we", s, 32'(bwe_o[s]), 32'd0);
    chk("idle_bus_oe", s, 32'(boe_o[s]), 32'd0);
    chk("idle_read_data", s, rd_o[s], last_rd[s]);
    chk("idle_bus_addr", s, 32'(ba_o[s]), 32'(held_addr));
  endtask

  // One full transaction: cycle-by-cycle bus checks, done timing, result, then the IDLE cycle.
  task automatic txn(input int s, input bit w, input logic [2:0] size, input logic [7:0] addr,
                     input logic [31:0] data, input bit drop, input bit keep);
    int ws, n, lat, j;
    logic [31:0] exp_rd;
    ws = (s == 1) ? 2 : 0;
    n = nbytes(size);
    lat = n * (ws + 1) + 1;
    exp_rd = w ? last_rd[s] : model_load(s, size, addr);
    req[s] = 1'b1; we[s] = w; sz[s] = size; ad[s] = addr; wd[s] = data;
    cyc();
    for (int c = 1; c <= lat; c++) begin
      if (drop && c == 2) req[s] = 1'b0;
      if (c < lat) begin
        j = (c - 1) / (ws + 1);
        chk("bus_addr", s, 32'(ba_o[s]), 32'((int'(addr) + j) % 256));
        chk("bus_we", s, 32'(bwe_o[s]), 32'(w));
        chk("bus_oe", s, 32'(boe_o[s]), w ? 32'hFF : 32'h0);
        chk("early_done", s, 32'(done_o[s]), 32'd0);
        chk("busy", s, 32'(busy_o[s]), 32'd1);
        if (w) begin
          chk("bus_wdata", s, 32'(bwd_o[s]), (data >> (8 * j)) & 32'hFF);
          mem[s][ba_o[s]] = bwd_o[s];
        end
      end else begin
        chk("done", s, 32'(done_o[s]), 32'd1);
        chk("done_bus_we", s, 32'(bwe_o[s]), 32'd0);
        chk("done_busy", s, 32'(busy_o[s]), 32'd1);
        chk("read_data", s, rd_o[s], exp_rd);
        if (!keep) req[s] = 1'b0;
      end
      cyc();
    end
    if (w) begin
      for (int i = 0; i < n; i++)
        refm[s][(int'(addr) + i) % 256] = 8'((data >> (8 * i)) & 32'hFF);
    end else begin
      last_rd[s] = exp_rd;
    end
    check_idle(s, 8'((int'(addr) + n - 1) % 256));
  endtask

  initial begin
    int s;
    bit w, drop, keep, prev_keep;
    logic [7:0] v;
    n_cmp = 0; n_bad = 0;
    reset_n = 1'b1;
    req = '0; we = '0; sz = '0; ad = '0; wd = '0;
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    for (int a = 0; a < 256; a++) begin
      v = 8'($urandom); mem[0][a] = v; refm[0][a] = v;
      v = 8'($urandom); mem[1][a] = v; refm[1][a] = v;
    end

    #2 reset_n = 1'b0;
    req = 2'b11; we[0] = 1'b1; sz[0] = 3'd2; ad[0] = 8'h20; wd[0] = 32'hDEADBEEF;
    repeat (3) cyc();
    check_zero(0); check_zero(1);

    req[1] = 1'b0;
    reset_n = 1'b1;
    txn(0, 1'b1, 3'd2, 8'h20, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("store_mem_top", 0, 32'(mem[0][8'h23]), 32'hDE);
    chk("other_idle", 1, 32'(busy_o[1]), 32'd0);

    mem[0][8'h10] = 8'h80; refm[0][8'h10] = 8'h80;
    txn(0, 1'b0, 3'b000, 8'h10, 32'h0, 1'b0, 1'b0);
    chk("signed_byte", 0, rd_o[0], 32'hFFFFFF80);
    txn(0, 1'b0, 3'b100, 8'h10, 32'h0, 1'b0, 1'b0);
    chk("unsigned_byte", 0, rd_o[0], 32'h00000080);

    mem[1][8'hFF] = 8'h34; refm[1][8'hFF] = 8'h34;
    mem[1][8'h00] = 8'h12; refm[1][8'h00] = 8'h12;
    txn(1, 1'b0, 3'b001, 8'hFF, 32'h0, 1'b0, 1'b0);
    chk("half_wrap", 1, rd_o[1], 32'h00001234);

    // Reset during byte 2 of a word store.
    req[0] = 1'b1; we[0] = 1'b1; sz[0] = 3'd2; ad[0] = 8'h40; wd[0] = 32'h11223344;
    cyc();
    cyc(); cyc();
    chk("mid_bus_addr", 0, 32'(ba_o[0]), 32'h42);
    chk("mid_bus_wdata", 0, 32'(bwd_o[0]), 32'h22);
    reset_n = 1'b0; req[0] = 1'b0;
    #1;
    check_zero(0); check_zero(1);
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    cyc();
    reset_n = 1'b1;
    repeat (3) begin
      cyc();
      check_idle(0, 8'h00);
    end

    txn(0, 1'b0, 3'd2, 8'h30, 32'h0, 1'b0, 1'b1);
    txn(0, 1'b1, 3'd1, 8'h31, 32'hCAFEBABE, 1'b0, 1'b0);
    txn(1, 1'b1, 3'd2, 8'hFE, 32'h0BADF00D, 1'b1, 1'b0);
    txn(1, 1'b0, 3'd2, 8'hFE, 32'h0, 1'b0, 1'b0);
    chk("store_readback", 1, rd_o[1], 32'h0BADF00D);

    prev_keep = 1'b0;
    s = 0;
    for (int t = 0; t < 60; t++) begin
      if (!prev_keep) s = int'($urandom_range(0, 1));
      w    = 1'($urandom_range(0, 1));
      drop = ($urandom_range(0, 3) == 0);
      keep = ($urandom_range(0, 3) == 0) && (t < 59);
      txn(s, w, 3'($urandom_range(0, 7)), 8'($urandom), $urandom, drop, keep);
      prev_keep = keep;
    end
    req = '0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
